// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared core widths, constants and the IF/ID record
package instruction_fetch_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  // addi x0, x0, 0: the canonical RV32I no-op used for pipeline bubbles
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTRUCTION = 32'h0000_0013;

  // default program counter after reset (word aligned)
  localparam logic [DATA_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // contents of the IF/ID pipeline register
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0]  pc;
    logic [DATA_WIDTH-1:0]  pc_plus4;
    logic                   valid;
    logic                   misaligned;
  } if_id_t;

  // bubble value: loaded on reset and on flush
  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.instr      = NOP_INSTRUCTION;
    b.pc         = '0;
    b.pc_plus4   = '0;
    b.valid      = 1'b0;
    b.misaligned = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_register.sv
// rtl/instruction_fetch_if_id_register.sv - stall/flush pipeline register over if_id_t
import instruction_fetch_pkg::*;

module if_id_register (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // flush beats stall; reset and flush both load the bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= if_id_bubble();
    end else if (flush) begin
      q <= if_id_bubble();
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - RV32I fetch stage: PC register, next-PC mux and IF/ID register
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_f,
  input  logic                   stall_d,
  input  logic                   flush_d,
  input  logic                   pc_src_e,
  input  logic [DATA_WIDTH-1:0]  pc_target_e,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic [INSTR_WIDTH-1:0] instr_d,
  output logic [DATA_WIDTH-1:0]  pc_d,
  output logic [DATA_WIDTH-1:0]  pc_plus4_d,
  output logic                   valid_d,
  output logic                   misaligned_d
);

  logic [DATA_WIDTH-1:0] pc_f;
  logic [DATA_WIDTH-1:0] pc_plus4_f;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  misaligned_f;
  if_id_t                fetch_rec;
  if_id_t                if_id_q;

  assign pc_plus4_f   = pc_f + 32'd4;
  assign misaligned_f = (pc_f[1:0] != 2'b00);
  assign imem_addr    = pc_f;

  // next-PC select: a redirect from Execute overrides the load-use stall
  always_comb begin
    pc_next = pc_plus4_f;
    if (pc_src_e) begin
      pc_next = pc_target_e;
    end else if (stall_f) begin
      pc_next = pc_f;
    end
  end

  // program counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  // record presented to IF/ID; a misaligned fetch carries a NOP and the flag
  always_comb begin
    fetch_rec            = if_id_bubble();
    fetch_rec.instr      = misaligned_f ? NOP_INSTRUCTION : imem_instr;
    fetch_rec.pc         = pc_f;
    fetch_rec.pc_plus4   = pc_plus4_f;
    fetch_rec.valid      = 1'b1;
    fetch_rec.misaligned = misaligned_f;
  end

  if_id_register u_if_id (
    .clk   (clk),
    .rst   (rst),
    .stall (stall_d),
    .flush (flush_d),
    .d     (fetch_rec),
    .q     (if_id_q)
  );

  assign instr_d      = if_id_q.instr;
  assign pc_d         = if_id_q.pc;
  assign pc_plus4_d   = if_id_q.pc_plus4;
  assign valid_d      = if_id_q.valid;
  assign misaligned_d = if_id_q.misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - table-driven scoreboard bench for instruction_fetch
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misaligned_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // address-tagged memory; low byte 0xB3 never collides with the NOP
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'hB3};
  endfunction

  assign imem_instr = mem_word(imem_addr);

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d),
    .pc_src_e     (pc_src_e),
    .pc_target_e  (pc_target_e),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .instr_d      (instr_d),
    .pc_d         (pc_d),
    .pc_plus4_d   (pc_plus4_d),
    .valid_d      (valid_d),
    .misaligned_d (misaligned_d)
  );

  typedef struct {
    logic        sf, sd, fd, src;
    logic [31:0] tgt;
    logic [31:0] e_addr, e_instr, e_pc, e_p4;
    logic        e_v, e_m;
  } vec_t;

  typedef struct {
    logic [31:0] addr, instr, pc, p4;
    logic        v, m;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  task automatic add(input logic sf, sd, fd, src, input logic [31:0] tgt,
                     input logic [31:0] ea, ei, ep, e4, input logic ev, em);
    vec_t r;
    r.sf = sf; r.sd = sd; r.fd = fd; r.src = src; r.tgt = tgt;
    r.e_addr = ea; r.e_instr = ei; r.e_pc = ep; r.e_p4 = e4; r.e_v = ev; r.e_m = em;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".imem_addr"},    imem_addr,            e.addr);
    check({tag, ".instr_d"},      instr_d,              e.instr);
    check({tag, ".pc_d"},         pc_d,                 e.pc);
    check({tag, ".pc_plus4_d"},   pc_plus4_d,           e.p4);
    check({tag, ".valid_d"},      {31'b0, valid_d},     {31'b0, e.v});
    check({tag, ".misaligned_d"}, {31'b0, misaligned_d}, {31'b0, e.m});
  endtask

  function automatic exp_t mk(input logic [31:0] a, i, p, q, input logic v, m);
    exp_t e;
    e.addr = a; e.instr = i; e.pc = p; e.p4 = q; e.v = v; e.m = m;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = '0;

    //   sf sd fd src tgt            addr after     instr_d        pc_d           pc_plus4_d     v  m
    add(0, 0, 0, 0, 32'h0,          32'h4,          32'h000000B3,  32'h0,         32'h4,         1, 0);
    add(0, 0, 0, 0, 32'h0,          32'h8,          32'h000004B3,  32'h4,         32'h8,         1, 0);
    add(0, 0, 0, 0, 32'h0,          32'hC,          32'h000008B3,  32'h8,         32'hC,         1, 0);
    add(0, 0, 1, 1, 32'h100,        32'h100,        32'h00000013,  32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,          32'h104,        32'h000100B3,  32'h100,       32'h104,       1, 0);
    add(0, 0, 1, 1, 32'h1C,         32'h1C,         32'h00000013,  32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,          32'h20,         32'h00001CB3,  32'h1C,        32'h20,        1, 0);
    add(1, 1, 0, 0, 32'h0,          32'h20,         32'h00001CB3,  32'h1C,        32'h20,        1, 0);
    add(1, 1, 0, 0, 32'h0,          32'h20,         32'h00001CB3,  32'h1C,        32'h20,        1, 0);
    add(0, 0, 0, 0, 32'h0,          32'h24,         32'h000020B3,  32'h20,        32'h24,        1, 0);
    add(0, 0, 0, 0, 32'h0,          32'h28,         32'h000024B3,  32'h24,        32'h28,        1, 0);
    add(1, 1, 1, 1, 32'h200,        32'h200,        32'h00000013,  32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,          32'h204,        32'h000200B3,  32'h200,       32'h204,       1, 0);
    add(0, 0, 1, 1, 32'h102,        32'h102,        32'h00000013,  32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,          32'h106,        32'h00000013,  32'h102,       32'h106,       1, 1);
    add(0, 0, 0, 0, 32'h0,          32'h10A,        32'h00000013,  32'h106,       32'h10A,       1, 1);
    add(0, 0, 1, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC,  32'h00000013,  32'h0,         32'h0,         0, 0);
    add(0, 0, 0, 0, 32'h0,          32'h0,          32'hFFFFFCB3,  32'hFFFF_FFFC, 32'h0,         1, 0);
    add(0, 0, 0, 0, 32'h0,          32'h4,          32'h000000B3,  32'h0,         32'h4,         1, 0);
    add(0, 1, 0, 0, 32'h0,          32'h8,          32'h000000B3,  32'h0,         32'h4,         1, 0);
    add(0, 0, 1, 0, 32'h0,          32'hC,          32'h00000013,  32'h0,         32'h0,         0, 0);
    add(1, 0, 0, 0, 32'h0,          32'hC,          32'h00000CB3,  32'hC,         32'h10,        1, 0);
    add(0, 0, 0, 0, 32'h0,          32'h10,         32'h00000CB3,  32'hC,         32'h10,        1, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", mk(32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0));
    rst = 1'b0;

    // table: expectation enters the scoreboard when its stimulus is driven
    for (int i = 0; i < vecs.size(); i++) begin
      stall_f = vecs[i].sf; stall_d = vecs[i].sd; flush_d = vecs[i].fd;
      pc_src_e = vecs[i].src; pc_target_e = vecs[i].tgt;
      exp_q.push_back(mk(vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc,
                         vecs[i].e_p4, vecs[i].e_v, vecs[i].e_m));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at vector %0d", i);
      end else begin
        e = exp_q.pop_front();
        check_all($sformatf("vec%0d", i), e);
      end
    end

    // async reset pulsed between edges while stalled
    stall_f = 1; stall_d = 1; flush_d = 0; pc_src_e = 0;
    @(posedge clk);
    #1;
    check("pre_rst.imem_addr", imem_addr, 32'h10);
    check("pre_rst.valid_d", {31'b0, valid_d}, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    check_all("async_rst", mk(32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 1'b0));
    #1;
    rst = 1'b0;
    stall_f = 0; stall_d = 0;
    @(posedge clk);
    #1;
    check_all("post_rst", mk(32'h4, 32'h000000B3, 32'h0, 32'h4, 1'b1, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
